// File: rtl/wasm_operand_stack.sv
// Operand stack for the WASM core. It presents the top three entries to the
// ALU and retires each instruction in one cycle: pop N operands, then
// optionally push the result. Underflow and overflow trap into a sticky
// FAULT state, which only fault_clr can leave.
module wasm_operand_stack #(
    parameter int ST_WIDTH = 32,
    parameter int DEPTH    = 16,
    localparam int DW      = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [1:0]          op_pop,
    input  logic                op_push,
    input  logic [ST_WIDTH-1:0] push_data,
    input  logic                fault_clr,
    output logic [ST_WIDTH-1:0] opnd_a,
    output logic [ST_WIDTH-1:0] opnd_b,
    output logic [ST_WIDTH-1:0] opnd_c,
    output logic [DW-1:0]       depth,
    output logic                empty,
    output logic                full,
    output logic                fault,
    output logic [1:0]          fault_code
);

    typedef enum logic {RUN, FAULT} state_t;

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_UNDER = 2'b01;
    localparam logic [1:0] CODE_OVER  = 2'b10;

    state_t              state_q, state_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic [1:0]          code_q, code_d;
    logic [ST_WIDTH-1:0] mem_q [DEPTH];

    logic                accept;
    logic                underflow;
    logic                overflow;
    logic                wr_en;
    // One spare bit keeps depth - op_pop from wrapping.
    logic [DW:0]         after_pop;
    logic [DW:0]         new_depth;

    assign op_ready   = (state_q == RUN) && !fault_clr;
    assign accept     = op_valid && op_ready;
    assign underflow  = (DW+1)'(op_pop) > {1'b0, depth_q};
    assign after_pop  = {1'b0, depth_q} - (DW+1)'(op_pop);
    assign new_depth  = after_pop + (DW+1)'(op_push);
    assign overflow   = new_depth > (DW+1)'(DEPTH);

    // Next-state: fault_clr dominates, then underflow, overflow, normal retire.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        code_d  = code_q;
        wr_en   = 1'b0;
        if (fault_clr) begin
            state_d = RUN;
            depth_d = '0;
            code_d  = CODE_NONE;
        end else if (accept) begin
            if (underflow) begin
                state_d = FAULT;
                code_d  = CODE_UNDER;
            end else if (overflow) begin
                state_d = FAULT;
                code_d  = CODE_OVER;
            end else begin
                depth_d = new_depth[DW-1:0];
                wr_en   = op_push;
            end
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            depth_q <= '0;
            code_q  <= CODE_NONE;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            code_q  <= code_d;
        end
    end

    // Storage array is not reset. The write is also gated by rst_n, so a
    // command caught by reset leaves no partial write behind.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst_n && wr_en && after_pop == (DW+1)'(gi)) begin
                    mem_q[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Top-of-stack reads are decoded from depth and are zero for invalid slots.
    always_comb begin
        opnd_a = '0;
        opnd_b = '0;
        opnd_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) opnd_a = mem_q[i];
            if (depth_q == DW'(i + 2)) opnd_b = mem_q[i];
            if (depth_q == DW'(i + 3)) opnd_c = mem_q[i];
        end
    end

    assign depth      = depth_q;
    assign empty      = (depth_q == '0);
    assign full       = (depth_q == DW'(DEPTH));
    assign fault      = (state_q == FAULT);
    assign fault_code = code_q;

endmodule

// File: tb/tb_wasm_operand_stack.sv
// Directed testbench for wasm_operand_stack: one task per scenario.
module tb_wasm_operand_stack;

    localparam int ST_WIDTH = 32;
    localparam int DEPTH    = 16;
    localparam int DW       = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                op_valid;
    logic                op_ready;
    logic [1:0]          op_pop;
    logic                op_push;
    logic [ST_WIDTH-1:0] push_data;
    logic                fault_clr;
    logic [ST_WIDTH-1:0] opnd_a, opnd_b, opnd_c;
    logic [DW-1:0]       depth;
    logic                empty, full, fault;
    logic [1:0]          fault_code;

    int checks   = 0;
    int failures = 0;

    wasm_operand_stack #(.ST_WIDTH(ST_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_pop(op_pop), .op_push(op_push), .push_data(push_data),
        .fault_clr(fault_clr),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .opnd_c(opnd_c),
        .depth(depth), .empty(empty), .full(full),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // Present one command from a falling edge, let it be taken at the rising edge, then drop it.
    task automatic do_cmd(input logic [1:0] p, input logic pu, input logic [31:0] d);
        @(negedge clk);
        op_valid = 1'b1; op_pop = p; op_push = pu; push_data = d;
        @(posedge clk);
        #1;
        op_valid = 1'b0; op_pop = 2'd0; op_push = 1'b0;
        $display("cmd pop=%0d push=%0d data=%h -> depth=%0d a=%h fault=%0d", p, pu, d, depth, opnd_a, fault);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (depth !== 5'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", depth); end
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", op_ready); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL reset_flags got e=%b f=%b flt=%b exp 1/0/0", empty, full, fault); end
        checks++; if (opnd_a !== 32'd0 || fault_code !== 2'b00) begin failures++; $display("FAIL reset_opnd got a=%h code=%b exp 0/00", opnd_a, fault_code); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_push();
        do_cmd(2'd0, 1'b1, 32'd5);
        do_cmd(2'd0, 1'b1, 32'd7);
        checks++; if (depth !== 5'd2) begin failures++; $display("FAIL push_depth got=%0d exp=2", depth); end
        checks++; if (opnd_a !== 32'd7 || opnd_b !== 32'd5 || opnd_c !== 32'd0) begin failures++; $display("FAIL push_opnd got=%h/%h/%h exp=7/5/0", opnd_a, opnd_b, opnd_c); end
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL push_empty got=%b exp=0", empty); end
    endtask

    task automatic test_alu();
        do_cmd(2'd2, 1'b1, 32'hFFFF_FFFE);
        checks++; if (depth !== 5'd1) begin failures++; $display("FAIL alu_depth got=%0d exp=1", depth); end
        checks++; if (opnd_a !== 32'hFFFF_FFFE || opnd_b !== 32'd0) begin failures++; $display("FAIL alu_opnd got=%h/%h exp=fffffffe/0", opnd_a, opnd_b); end
        do_cmd(2'd1, 1'b0, 32'd0);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL alu_pop_empty got=%b exp=1", empty); end
    endtask

    task automatic test_select();
        do_cmd(2'd0, 1'b1, 32'd11);
        do_cmd(2'd0, 1'b1, 32'd22);
        do_cmd(2'd0, 1'b1, 32'd0);
        checks++; if (opnd_a !== 32'd0 || opnd_b !== 32'd22 || opnd_c !== 32'd11) begin failures++; $display("FAIL sel_pre got=%h/%h/%h exp=0/22/11", opnd_a, opnd_b, opnd_c); end
        do_cmd(2'd3, 1'b1, 32'd22);
        checks++; if (depth !== 5'd1 || opnd_a !== 32'd22) begin failures++; $display("FAIL sel_post got depth=%0d a=%0d exp 1/22", depth, opnd_a); end
        do_cmd(2'd1, 1'b0, 32'd0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) begin
            do_cmd(2'd0, 1'b1, 32'(i + 1));
            checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, op_ready); end
        end
        checks++; if (full !== 1'b1 || depth !== 5'd16) begin failures++; $display("FAIL b2b_full got full=%b depth=%0d exp 1/16", full, depth); end
        checks++; if (opnd_a !== 32'd16 || opnd_b !== 32'd15 || opnd_c !== 32'd14) begin failures++; $display("FAIL b2b_top got=%0d/%0d/%0d exp=16/15/14", opnd_a, opnd_b, opnd_c); end
        // Replacing the top while full is legal.
        do_cmd(2'd1, 1'b1, 32'd77);
        checks++; if (fault !== 1'b0 || depth !== 5'd16 || opnd_a !== 32'd77) begin failures++; $display("FAIL full_replace got flt=%b depth=%0d a=%0d exp 0/16/77", fault, depth, opnd_a); end
        do_cmd(2'd0, 1'b1, 32'd99);
        checks++; if (fault !== 1'b1 || fault_code !== 2'b10) begin failures++; $display("FAIL ovf_fault got flt=%b code=%b exp 1/10", fault, fault_code); end
        checks++; if (depth !== 5'd16 || op_ready !== 1'b0 || opnd_a !== 32'd77) begin failures++; $display("FAIL ovf_hold got depth=%0d rdy=%b a=%0d exp 16/0/77", depth, op_ready, opnd_a); end
        do_cmd(2'd2, 1'b0, 32'd0);
        do_cmd(2'd1, 1'b1, 32'd5);
        checks++; if (depth !== 5'd16 || opnd_a !== 32'd77 || fault_code !== 2'b10) begin failures++; $display("FAIL ovf_ignore got depth=%0d a=%0d code=%b exp 16/77/10", depth, opnd_a, fault_code); end
        @(negedge clk); fault_clr = 1'b1;
        @(posedge clk); #1;
        checks++; if (fault !== 1'b0 || depth !== 5'd0 || fault_code !== 2'b00) begin failures++; $display("FAIL ovf_clr got flt=%b depth=%0d code=%b exp 0/0/00", fault, depth, fault_code); end
        @(negedge clk); fault_clr = 1'b0;
    endtask

    task automatic test_underflow();
        do_cmd(2'd1, 1'b0, 32'd0);
        checks++; if (fault !== 1'b1 || fault_code !== 2'b01 || depth !== 5'd0) begin failures++; $display("FAIL udf got flt=%b code=%b depth=%0d exp 1/01/0", fault, fault_code, depth); end
        @(negedge clk);
        fault_clr = 1'b1; op_valid = 1'b1; op_push = 1'b1; push_data = 32'd123;
        #1;
        checks++; if (op_ready !== 1'b0) begin failures++; $display("FAIL clr_ready got=%b exp=0", op_ready); end
        @(posedge clk); #1;
        checks++; if (fault !== 1'b0 || depth !== 5'd0 || fault_code !== 2'b00) begin failures++; $display("FAIL clr_state got flt=%b depth=%0d code=%b exp 0/0/00", fault, depth, fault_code); end
        @(negedge clk);
        fault_clr = 1'b0; op_valid = 1'b0; op_push = 1'b0;
        #1;
        checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL clr_ready_after got=%b exp=1", op_ready); end
    endtask

    task automatic test_reset_mid();
        do_cmd(2'd0, 1'b1, 32'd1);
        do_cmd(2'd0, 1'b1, 32'd2);
        do_cmd(2'd0, 1'b1, 32'd3);
        @(negedge clk);
        op_valid = 1'b1; op_push = 1'b1; push_data = 32'd55;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (depth !== 5'd0 || opnd_a !== 32'd0 || empty !== 1'b1 || op_ready !== 1'b1) begin failures++; $display("FAIL rst_mid got depth=%0d a=%0d e=%b rdy=%b exp 0/0/1/1", depth, opnd_a, empty, op_ready); end
        @(posedge clk); #1;
        checks++; if (depth !== 5'd0) begin failures++; $display("FAIL rst_mid_edge got depth=%0d exp=0", depth); end
        @(negedge clk);
        op_valid = 1'b0; op_push = 1'b0; rst_n = 1'b1;
        do_cmd(2'd0, 1'b1, 32'd42);
        checks++; if (depth !== 5'd1 || opnd_a !== 32'd42 || opnd_b !== 32'd0) begin failures++; $display("FAIL rst_after got depth=%0d a=%0d b=%0d exp 1/42/0", depth, opnd_a, opnd_b); end
        do_cmd(2'd0, 1'b0, 32'd9);
        checks++; if (depth !== 5'd1 || opnd_a !== 32'd42 || fault !== 1'b0) begin failures++; $display("FAIL noop got depth=%0d a=%0d flt=%b exp 1/42/0", depth, opnd_a, fault); end
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_pop = 2'd0; op_push = 1'b0;
        push_data = '0; fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_push();
        test_alu();
        test_select();
        test_back_to_back();
        test_underflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
